scr1_tb_instr_trace_fifo: RTL and testbench

Testbench trace-capture stage that sits on the IFU→IDU instruction handshake and feeds the downstream instruction logger. It matches instructions against a runtime opcode/funct3 pattern and timestamps each accepted match with PC and mcycle. Matches are buffered in a show-ahead FIFO drained over a valid/ready interface. Matches are never lost silently: a full FIFO drops the event and the drop is counted.

---
 rtl/scr1_tb_instr_trace_fifo.sv | 116 +++++++++++
 tb/tb_scr1_tb_instr_trace_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tb_instr_trace_fifo.sv
// Trace-capture FIFO on the IFU->IDU handshake: buffers opcode/funct3 matches with PC and mcycle.
// Optional macro SCR1_TRC_FUNCT3_MATCH_EN adds funct3 to the match condition.
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif

module scr1_tb_instr_trace_fifo #(
  parameter int unsigned DEPTH                   = 8,
  parameter int unsigned CNT_W                   = 16,
  parameter int unsigned SCR1_CSR_COUNTERS_WIDTH = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ifu2idu_vd_i,
  input  logic                               idu2ifu_rdy_i,
  input  logic [31:0]                        ifu2idu_instr_i,
  input  logic [`SCR1_XLEN-1:0]              pc_i,
  input  logic [SCR1_CSR_COUNTERS_WIDTH-1:0] mcycle_i,
  input  logic [6:0]                         match_opcode_i,
  input  logic [2:0]                         match_funct3_i,
  input  logic                               clr_i,
  output logic                               trc_vd_o,
  input  logic                               trc_rdy_i,
  output logic [`SCR1_XLEN-1:0]              trc_pc_o,
  output logic [31:0]                        trc_instr_o,
  output logic [SCR1_CSR_COUNTERS_WIDTH-1:0] trc_mcycle_o,
  output logic [$clog2(DEPTH):0]             trc_cnt_o,
  output logic [CNT_W-1:0]                   drop_cnt_o,
  output logic                               overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [`SCR1_XLEN-1:0]              pc_mem    [DEPTH];
  logic [31:0]                        instr_mem [DEPTH];
  logic [SCR1_CSR_COUNTERS_WIDTH-1:0] mcyc_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             ovf;

  logic opc_hit;
  logic f3_hit;
  logic match;
  logic full;
  logic pop;
  logic push;
  logic drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign opc_hit = (ifu2idu_instr_i[6:0] == match_opcode_i);
`ifdef SCR1_TRC_FUNCT3_MATCH_EN
  assign f3_hit  = (ifu2idu_instr_i[14:12] == match_funct3_i);
`else
  // Opcode-only matching; the funct3 pattern port is kept for interface compatibility.
  logic unused_funct3;
  assign unused_funct3 = ^match_funct3_i;
  assign f3_hit  = 1'b1;
`endif

  assign match = ifu2idu_vd_i & idu2ifu_rdy_i & opc_hit & f3_hit;
  assign full  = (cnt == FULL_CNT);
  assign pop   = trc_vd_o & trc_rdy_i;
  assign push  = match & (~full | pop);
  assign drop  = match & full & ~pop;

  // Control state: pointers, occupancy, drop statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else if (clr_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push & ~pop)      cnt <= cnt + (PTR_W+1)'(1);
      else if (pop & ~push) cnt <= cnt - (PTR_W+1)'(1);
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
        ovf      <= 1'b1;
      end
    end
  end

  // Storage is data-only and deliberately left unreset
  always_ff @(posedge clk) begin
    if (push & ~clr_i) begin
      pc_mem[wr_ptr]    <= pc_i;
      instr_mem[wr_ptr] <= ifu2idu_instr_i;
      mcyc_mem[wr_ptr]  <= mcycle_i;
    end
  end

  assign trc_vd_o     = (cnt != '0);
  assign trc_pc_o     = pc_mem[rd_ptr];
  assign trc_instr_o  = instr_mem[rd_ptr];
  assign trc_mcycle_o = mcyc_mem[rd_ptr];
  assign trc_cnt_o    = cnt;
  assign drop_cnt_o   = drop_cnt;
  assign overflow_o   = ovf;

endmodule

// File: tb/tb_scr1_tb_instr_trace_fifo.sv
// Self-checking bench for scr1_tb_instr_trace_fifo against a queue-based reference model.
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif

module tb_scr1_tb_instr_trace_fifo;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int MW    = 64;
  localparam logic [6:0] OPC = 7'b0110011;
  localparam logic [2:0] F3  = 3'b100;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  ifu2idu_vd_i = 1'b0;
  logic                  idu2ifu_rdy_i = 1'b0;
  logic [31:0]           ifu2idu_instr_i = '0;
  logic [`SCR1_XLEN-1:0] pc_i = '0;
  logic [MW-1:0]         mcycle_i = '0;
  logic [6:0]            match_opcode_i = OPC;
  logic [2:0]            match_funct3_i = F3;
  logic                  clr_i = 1'b0;
  logic                  trc_vd_o;
  logic                  trc_rdy_i = 1'b0;
  logic [`SCR1_XLEN-1:0] trc_pc_o;
  logic [31:0]           trc_instr_o;
  logic [MW-1:0]         trc_mcycle_o;
  logic [3:0]            trc_cnt_o;
  logic [CNT_W-1:0]      drop_cnt_o;
  logic                  overflow_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [63:0] mcyc;
  } ent_t;

  ent_t q[$];
  int   m_drop = 0;
  bit   m_ovf  = 1'b0;
  int   checks = 0;
  int   failures = 0;

  scr1_tb_instr_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .SCR1_CSR_COUNTERS_WIDTH(MW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ifu2idu_vd_i    (ifu2idu_vd_i),
    .idu2ifu_rdy_i   (idu2ifu_rdy_i),
    .ifu2idu_instr_i (ifu2idu_instr_i),
    .pc_i            (pc_i),
    .mcycle_i        (mcycle_i),
    .match_opcode_i  (match_opcode_i),
    .match_funct3_i  (match_funct3_i),
    .clr_i           (clr_i),
    .trc_vd_o        (trc_vd_o),
    .trc_rdy_i       (trc_rdy_i),
    .trc_pc_o        (trc_pc_o),
    .trc_instr_o     (trc_instr_o),
    .trc_mcycle_o    (trc_mcycle_o),
    .trc_cnt_o       (trc_cnt_o),
    .drop_cnt_o      (drop_cnt_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model by the rules of the block, then step past the edge.
  task automatic cyc(input logic vd, input logic rdy, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [63:0] mc, input logic trdy, input logic clr);
    bit   hit;
    bit   m;
    bit   p;
    bit   full;
    ent_t e;
    ifu2idu_vd_i = vd; idu2ifu_rdy_i = rdy; ifu2idu_instr_i = ins;
    pc_i = pc; mcycle_i = mc; trc_rdy_i = trdy; clr_i = clr;
    hit = (ins[6:0] == match_opcode_i);
`ifdef SCR1_TRC_FUNCT3_MATCH_EN
    hit = hit && (ins[14:12] == match_funct3_i);
`endif
    m    = vd && rdy && hit;
    p    = (q.size() != 0) && trdy;
    full = (q.size() == DEPTH);
    if (clr) begin
      q.delete(); m_drop = 0; m_ovf = 1'b0;
    end else begin
      if (p) void'(q.pop_front());
      if (m) begin
        if (!full || p) begin
          e.pc = pc; e.instr = ins; e.mcyc = mc;
          q.push_back(e);
        end else begin
          if (m_drop < (1 << CNT_W) - 1) m_drop++;
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic trdy);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 64'h0, trdy, 1'b0);
  endtask

  function automatic logic [31:0] mk_match(input logic [31:0] r);
    logic [31:0] v;
    v = r;
    v[6:0] = OPC;
    v[14:12] = F3;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (trc_vd_o !== 1'b0) begin failures++; $display("FAIL reset_vd got=%b want=0", trc_vd_o); end
    if (trc_cnt_o !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", trc_cnt_o); end
    if (drop_cnt_o !== '0) begin failures++; $display("FAIL reset_drop got=%0d want=0", drop_cnt_o); end
    if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", overflow_o); end
    rst_n = 1'b1;
    idle(1'b0);
  endtask

  task automatic test_single_match();
    cyc(1'b1, 1'b1, 32'h00C5C533, 32'h200, 64'h40, 1'b0, 1'b0);
    checks += 5;
    if (trc_vd_o !== 1'b1) begin failures++; $display("FAIL single_vd got=%b want=1", trc_vd_o); end
    if (trc_pc_o !== 32'h200) begin failures++; $display("FAIL single_pc got=%h want=00000200", trc_pc_o); end
    if (trc_instr_o !== 32'h00C5C533) begin failures++; $display("FAIL single_instr got=%h want=00c5c533", trc_instr_o); end
    if (trc_mcycle_o !== 64'h40) begin failures++; $display("FAIL single_mcycle got=%h want=40", trc_mcycle_o); end
    if (trc_cnt_o !== 4'd1) begin failures++; $display("FAIL single_cnt got=%0d want=1", trc_cnt_o); end
    idle(1'b1);
    checks++;
    if (trc_vd_o !== 1'b0) begin failures++; $display("FAIL single_pop_vd got=%b want=0", trc_vd_o); end
  endtask

  task automatic test_funct3_filter();
    logic [3:0] want;
`ifdef SCR1_TRC_FUNCT3_MATCH_EN
    want = 4'd0;
`else
    want = 4'd1;
`endif
    cyc(1'b1, 1'b1, 32'h00C58533, 32'h300, 64'h55, 1'b0, 1'b0);
    checks++;
    if (trc_cnt_o !== want) begin failures++; $display("FAIL funct3_cnt got=%0d want=%0d", trc_cnt_o, want); end
    if (q.size() != 0) begin
      checks++;
      if (trc_instr_o !== 32'h00C58533) begin failures++; $display("FAIL funct3_instr got=%h want=00c58533", trc_instr_o); end
    end
    while (q.size() != 0) idle(1'b1);
  endtask

  task automatic test_valid_no_ready();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 32'h00C5C533, 32'h400 + 4 * i, 64'(i), 1'b0, 1'b0);
      checks++;
      if (trc_cnt_o !== 4'd0) begin failures++; $display("FAIL novalid_cnt cyc=%0d got=%0d want=0", i, trc_cnt_o); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b1, mk_match($urandom), 32'h1000 + 4 * i, {$urandom, $urandom}, 1'b0, 1'b0);
    checks += 3;
    if (trc_cnt_o !== 4'd8) begin failures++; $display("FAIL ovf_cnt got=%0d want=8", trc_cnt_o); end
    if (drop_cnt_o !== 16'd2) begin failures++; $display("FAIL ovf_drop got=%0d want=2", drop_cnt_o); end
    if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", overflow_o); end
    for (int i = 0; i < 8; i++) begin
      checks += 3;
      if (trc_pc_o !== 32'h1000 + 4 * i) begin failures++; $display("FAIL ovf_drain_pc idx=%0d got=%h want=%h", i, trc_pc_o, 32'h1000 + 4 * i); end
      if (trc_instr_o !== q[0].instr) begin failures++; $display("FAIL ovf_drain_instr idx=%0d got=%h want=%h", i, trc_instr_o, q[0].instr); end
      if (trc_mcycle_o !== q[0].mcyc) begin failures++; $display("FAIL ovf_drain_mcyc idx=%0d got=%h want=%h", i, trc_mcycle_o, q[0].mcyc); end
      idle(1'b1);
    end
    checks++;
    if (trc_vd_o !== 1'b0) begin failures++; $display("FAIL ovf_empty_vd got=%b want=0", trc_vd_o); end
  endtask

  task automatic test_full_push_pop();
    int d0;
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 1'b1, mk_match($urandom), $urandom, {$urandom, $urandom}, 1'b0, 1'b0);
    d0 = m_drop;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cyc(1'b1, 1'b1, mk_match($urandom), $urandom, {$urandom, $urandom}, 1'b1, 1'b0);
      checks += 5;
      if (trc_cnt_o !== 4'd8) begin failures++; $display("FAIL fullpp_cnt i=%0d got=%0d want=8", i, trc_cnt_o); end
      if (drop_cnt_o !== 16'(d0)) begin failures++; $display("FAIL fullpp_drop i=%0d got=%0d want=%0d", i, drop_cnt_o, d0); end
      if (trc_pc_o !== q[0].pc) begin failures++; $display("FAIL fullpp_pc i=%0d got=%h want=%h", i, trc_pc_o, q[0].pc); end
      if (trc_instr_o !== q[0].instr) begin failures++; $display("FAIL fullpp_instr i=%0d got=%h want=%h", i, trc_instr_o, q[0].instr); end
      if (trc_mcycle_o !== q[0].mcyc) begin failures++; $display("FAIL fullpp_mcyc i=%0d got=%h want=%h", i, trc_mcycle_o, q[0].mcyc); end
    end
    while (q.size() != 0) begin
      checks++;
      if (trc_pc_o !== q[0].pc) begin failures++; $display("FAIL fullpp_drain_pc got=%h want=%h", trc_pc_o, q[0].pc); end
      idle(1'b1);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 2) != 0) ins[6:0] = OPC;
      if ($urandom_range(0, 1) != 0) ins[14:12] = F3;
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), ins, $urandom,
          {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));
      checks += 4;
      if (trc_cnt_o !== 4'(q.size())) begin failures++; $display("FAIL rand_cnt i=%0d got=%0d want=%0d", i, trc_cnt_o, q.size()); end
      if (trc_vd_o !== (q.size() != 0)) begin failures++; $display("FAIL rand_vd i=%0d got=%b want=%b", i, trc_vd_o, q.size() != 0); end
      if (drop_cnt_o !== 16'(m_drop)) begin failures++; $display("FAIL rand_drop i=%0d got=%0d want=%0d", i, drop_cnt_o, m_drop); end
      if (overflow_o !== m_ovf) begin failures++; $display("FAIL rand_ovf i=%0d got=%b want=%b", i, overflow_o, m_ovf); end
      if (q.size() != 0) begin
        checks++;
        if ({trc_pc_o, trc_instr_o, trc_mcycle_o} !== q[0]) begin
          failures++;
          $display("FAIL rand_head i=%0d got=%h_%h_%h want=%h_%h_%h", i, trc_pc_o, trc_instr_o, trc_mcycle_o, q[0].pc, q[0].instr, q[0].mcyc);
        end
      end
    end
  endtask

  task automatic test_clear();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++)
      cyc(1'b1, 1'b1, mk_match($urandom), $urandom, {$urandom, $urandom}, 1'b0, 1'b0);
    repeat (3) idle(1'b1);
    checks += 2;
    if (trc_cnt_o !== 4'd5) begin failures++; $display("FAIL clr_pre_cnt got=%0d want=5", trc_cnt_o); end
    if (drop_cnt_o !== 16'd3) begin failures++; $display("FAIL clr_pre_drop got=%0d want=3", drop_cnt_o); end
    cyc(1'b1, 1'b1, mk_match($urandom), 32'h5000, 64'h1, 1'b1, 1'b1);
    checks += 4;
    if (trc_cnt_o !== 4'd0) begin failures++; $display("FAIL clr_cnt got=%0d want=0", trc_cnt_o); end
    if (trc_vd_o !== 1'b0) begin failures++; $display("FAIL clr_vd got=%b want=0", trc_vd_o); end
    if (drop_cnt_o !== 16'd0) begin failures++; $display("FAIL clr_drop got=%0d want=0", drop_cnt_o); end
    if (overflow_o !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b want=0", overflow_o); end
    idle(1'b0);
    checks++;
    if (trc_cnt_o !== 4'd0) begin failures++; $display("FAIL clr_after_cnt got=%0d want=0", trc_cnt_o); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, mk_match($urandom), $urandom, {$urandom, $urandom}, 1'b0, 1'b0);
    idle(1'b1);
    checks++;
    if (trc_cnt_o !== 4'd2) begin failures++; $display("FAIL arst_pre_cnt got=%0d want=2", trc_cnt_o); end
    trc_rdy_i = 1'b1;
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (trc_vd_o !== 1'b0) begin failures++; $display("FAIL arst_vd got=%b want=0", trc_vd_o); end
    if (trc_cnt_o !== 4'd0) begin failures++; $display("FAIL arst_cnt got=%0d want=0", trc_cnt_o); end
    q.delete(); m_drop = 0; m_ovf = 1'b0;
    #1;
    rst_n = 1'b1;
    idle(1'b1);
    checks++;
    if (trc_cnt_o !== 4'd0) begin failures++; $display("FAIL arst_after_cnt got=%0d want=0", trc_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_funct3_filter();
    test_valid_no_ready();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
